memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single RAM port between icache (instruction fill reads) and dcache (data reads/writes).
- Sits between the cache pair and the RAM model. Each requester sees a wait/load handshake; the RAM sees one REN/WEN/addr/store bundle.
- Data side has priority. A streak counter guarantees instruction forward progress under sustained data traffic.

Parameters:
- WORD_W, 32, data and address width.
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits before the instruction side is forced.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache word address
- iwait  out  1  0 = iload valid this cycle, transaction complete
- iload  out  WORD_W  instruction word
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  WORD_W  dcache word address
- dstore  in  WORD_W  write data
- dwait  out  1  0 = data transaction complete this cycle
- dload  out  WORD_W  read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- merr  out  1  one-cycle pulse: granted transaction ended in ERROR

Behaviour:
- Reset (async, nRST low):
  - State = IDLE, streak = 0.
  - All RAM enables 0; ramaddr/ramstore 0.
  - iwait = dwait = 1; iload = dload = 0; merr = 0.
- States: IDLE, IGRANT, DGRANT.
- IDLE, arbitration on current-cycle inputs; next state is registered:
  - D pending = dREN | dWEN.
  - Only D pending -> DGRANT. Only iREN -> IGRANT.
  - Both pending: streak == STARVE_LIMIT -> IGRANT; otherwise DGRANT.
  - Neither pending -> stay IDLE.
  - No RAM enable is driven in IDLE, so minimum turnaround is 1 cycle between transactions.
- Streak counter:
  - Increments on entry to DGRANT while iREN = 1, saturating at STARVE_LIMIT.
  - Clears on entry to IGRANT, or on any IDLE cycle with iREN = 0.
- IGRANT:
  - ramREN = 1, ramaddr = {iaddr[WORD_W-1:2], 2'b00}.
  - ramstate == ACCESS: iwait = 0 and iload = ramload this cycle; next state IDLE.
  - Otherwise iwait = 1.
- DGRANT:
  - ramaddr = {daddr[WORD_W-1:2], 2'b00}.
  - If dWEN: ramWEN = 1, ramstore = dstore, ramREN = 0. dWEN takes precedence when dREN and dWEN are both set.
  - Else: ramREN = 1.
  - ramstate == ACCESS: dwait = 0, dload = ramload (don't-care on writes); next state IDLE.
- The non-granted side always sees wait = 1 and load = 0.
- ERROR while granted:
  - merr pulses 1; granted wait stays 1; next state IDLE.
  - The requester re-requests naturally.
- Abort: granted requester drops its enables before ACCESS -> RAM enables drop the same cycle (combinational); next state IDLE; no completion.
- FREE/BUSY while granted: hold state and outputs unchanged.
- Address or data changes mid-grant pass straight through. Requesters are required to hold them stable.
- Mid-transaction reset: all outputs go to reset values immediately; no completion is signalled.

Test Plan:
- Reset with iREN = 1, dREN = 1 -> iwait = dwait = 1, ramREN = ramWEN = 0, state IDLE until nRST rises.
- iREN = 1, iaddr = 0x40, RAM 2 BUSY cycles then ACCESS with ramload = 0x8C010004 -> ramaddr = 0x40 for 3 cycles, iwait = 0 with iload = 0x8C010004 on cycle 3, then one IDLE cycle.
- dWEN = 1, daddr = 0x1003, dstore = 0xDEADBEEF -> ramaddr = 0x1000, ramWEN = 1, ramREN = 0, ramstore = 0xDEADBEEF; dwait = 0 on ACCESS.
- iREN and dREN held continuously, RAM completes in 1 cycle -> grant sequence D, D, D, D, I, D, D, D, D, I (STARVE_LIMIT = 4); no instruction wait exceeds 9 transactions.
- DGRANT read, ramstate = ERROR -> merr = 1 for one cycle, dwait stays 1, state returns to IDLE, then re-grant.
- IGRANT, iREN dropped after 1 BUSY cycle -> ramREN = 0 the same cycle, iwait never 0, pending dREN granted next.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - cache-pair / RAM bundle seen by the memory arbiter
// Purpose: groups the icache, dcache and RAM handshake signals of the arbiter.
// Modports:
//   slave  - the arbiter: takes cache requests and RAM status, drives waits/loads and RAM controls
//   master - the environment (caches + RAM): drives requests and RAM status, observes the rest
interface memory_arbiter_if #(
   parameter int WORD_W = 32
);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic [1:0]        ramstate;
   logic              merr;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
   );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one RAM port between icache fills and dcache reads/writes
// Purpose: data side wins arbitration; a streak counter forces an instruction grant after
//          STARVE_LIMIT consecutive data grants taken while an instruction request waited.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - memory_arbiter_if.slave: icache/dcache requests, waits and loads, RAM controls/status
module memory_arbiter #(
   parameter int WORD_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic             CLK,
   input logic             nRST,
   memory_arbiter_if.slave bus
);
   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);
   localparam logic [1:0]    RAM_ACCESS = 2'd2;
   localparam logic [1:0]    RAM_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          d_pend;
   logic          ram_done;
   logic          ram_err;
   logic          i_starved;

   assign d_pend    = bus.dREN | bus.dWEN;
   assign ram_done  = (bus.ramstate == RAM_ACCESS);
   assign ram_err   = (bus.ramstate == RAM_ERROR);
   assign i_starved = bus.iREN && (streak_q == LIMIT);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      case (state_q)
         IDLE: begin
            // An idle cycle with no instruction request ends any starvation history.
            if (!bus.iREN) streak_d = '0;
            if (d_pend && !i_starved) begin
               state_d = DGRANT;
               if (bus.iREN && (streak_q != LIMIT)) streak_d = streak_q + 1'b1;
            end else if (bus.iREN) begin
               state_d  = IGRANT;
               streak_d = '0;
            end
         end
         // Leaving on a dropped request is the abort path: no completion is signalled.
         IGRANT:  if (!bus.iREN || ram_done || ram_err) state_d = IDLE;
         DGRANT:  if (!d_pend || ram_done || ram_err) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      bus.dwait    = 1'b1;
      bus.dload    = '0;
      bus.merr     = 1'b0;
      case (state_q)
         IGRANT: begin
            bus.ramaddr = {bus.iaddr[WORD_W-1:2], 2'b00};
            if (bus.iREN) begin
               bus.ramREN = 1'b1;
               bus.merr   = ram_err;
               if (ram_done) begin
                  bus.iwait = 1'b0;
                  bus.iload = bus.ramload;
               end
            end
         end
         DGRANT: begin
            bus.ramaddr = {bus.daddr[WORD_W-1:2], 2'b00};
            // A write wins over a read when both enables are raised together.
            if (bus.dWEN) begin
               bus.ramWEN   = 1'b1;
               bus.ramstore = bus.dstore;
            end else if (bus.dREN) begin
               bus.ramREN = 1'b1;
            end
            if (d_pend) begin
               bus.merr = ram_err;
               if (ram_done) begin
                  bus.dwait = 1'b0;
                  bus.dload = bus.ramload;
               end
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter with a behavioural RAM and cache models
module tb_memory_arbiter;
   localparam int         W    = 32;
   localparam int         LIM  = 4;
   localparam logic [1:0] FREE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          wr;
   } txn_t;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   memory_arbiter_if #(.WORD_W(W)) bus ();

   memory_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIM)) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          errors = 0;
   txn_t        iq[$];
   txn_t        dq[$];
   bit          gq[$];
   logic [31:0] ref_mem[2048];
   logic [31:0] ram_mem[2048];
   logic [1:0]  rs = FREE;
   bit          mem_init = 0;
   bit          in_txn = 0;
   bit          err_this = 0;
   int          busy_left = 0;
   int          dir_lat = 0;
   bit          dir_err = 0;
   bit          rand_mode = 0;
   int          d_while_i = 0;
   txn_t        mon_e;
   bit          mon_g;

   assign bus.ramstate = rs;
   assign bus.ramload  = ram_mem[bus.ramaddr[12:2]];

   function automatic logic [31:0] init_word(int i);
      if (i == 16) return 32'h8C010004;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // RAM model: after a new enable, BUSY for the chosen latency, then ACCESS (or ERROR).
   always @(posedge CLK) begin
      #2;
      if (!mem_init) begin
         for (int i = 0; i < 2048; i++) ram_mem[i] = init_word(i);
         mem_init = 1;
      end
      if (!(bus.ramREN || bus.ramWEN)) begin
         in_txn = 0;
         rs     = FREE;
      end else begin
         if (!in_txn) begin
            in_txn = 1;
            if (rand_mode) begin
               busy_left = $urandom_range(0, 2);
               err_this  = ($urandom_range(0, 15) == 0);
            end else begin
               busy_left = dir_lat;
               err_this  = dir_err;
               dir_err   = 0;
            end
         end
         if (busy_left > 0) begin
            rs = BUSY;
            busy_left--;
         end else begin
            rs     = err_this ? ERR : ACC;
            in_txn = 0;
            if (!err_this && bus.ramWEN) ram_mem[bus.ramaddr[12:2]] = bus.ramstore;
         end
      end
   end

   // Monitor: pops expected responses whenever a requester sees completion.
   always @(negedge CLK) begin
      if (nRST === 1'b1) begin
         if (!bus.iREN) d_while_i = 0;
         if (bus.ramREN && bus.ramWEN) chk("ram_both_enables", 32'd1, 32'd0);
         if (!bus.iwait && !bus.dwait) chk("both_complete", 32'd1, 32'd0);
         if (rs == ERR && (bus.ramREN || bus.ramWEN)) begin
            chk("merr_on_error", {31'b0, bus.merr}, 32'd1);
            chk("err_iwait", {31'b0, bus.iwait}, 32'd1);
            chk("err_dwait", {31'b0, bus.dwait}, 32'd1);
            if (bus.iREN && bus.ramaddr >= 32'h200) d_while_i++;
            if (bus.ramaddr < 32'h200) d_while_i = 0;
         end else if (bus.merr !== 1'b0) begin
            chk("merr_spurious", {31'b0, bus.merr}, 32'd0);
         end
         if (!bus.iwait || !bus.dwait) begin
            if (gq.size() > 0) begin
               mon_g = gq.pop_front();
               chk("grant_order", {31'b0, !bus.iwait}, {31'b0, mon_g});
            end
         end
         if (!bus.dwait) begin
            if (bus.iREN) d_while_i++;
            if (dq.size() == 0) begin
               chk("d_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = dq.pop_front();
               chk("d_ramaddr", bus.ramaddr, mon_e.addr);
               chk("d_iload_idle", bus.iload, 32'd0);
               if (mon_e.wr) begin
                  chk("d_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
                  chk("d_ramstore", bus.ramstore, mon_e.data);
               end else begin
                  chk("d_ramREN", {31'b0, bus.ramREN}, 32'd1);
                  chk("dload", bus.dload, mon_e.data);
               end
            end
         end
         if (!bus.iwait) begin
            chk("starve_bound", {31'b0, d_while_i <= LIM + 1}, 32'd1);
            d_while_i = 0;
            if (iq.size() == 0) begin
               chk("i_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = iq.pop_front();
               chk("i_ramaddr", bus.ramaddr, mon_e.addr);
               chk("iload", bus.iload, mon_e.data);
               chk("i_dload_idle", bus.dload, 32'd0);
            end
         end
      end
   end

   task automatic icache_run(input int n);
      int a;
      int t;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         cyc();
         a = $urandom_range(0, 127);
         iq.push_back('{32'(a) << 2, ref_mem[a], 1'b0});
         bus.iaddr = (32'(a) << 2) | 32'($urandom_range(0, 3));
         bus.iREN  = 1'b1;
         t = 0;
         do begin
            @(negedge CLK);
            t++;
         end while (bus.iwait !== 1'b0 && t < 200);
         if (t >= 200) chk("i_timeout", 32'd1, 32'd0);
         cyc();
         bus.iREN = 1'b0;
      end
   endtask

   task automatic dcache_run(input int n);
      int a;
      int t;
      logic [31:0] v;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         cyc();
         a = $urandom_range(128, 2047);
         bus.daddr = (32'(a) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom;
            ref_mem[a] = v;
            dq.push_back('{32'(a) << 2, v, 1'b1});
            bus.dstore = v;
            bus.dWEN   = 1'b1;
            bus.dREN   = 1'($urandom_range(0, 1));
         end else begin
            dq.push_back('{32'(a) << 2, ref_mem[a], 1'b0});
            bus.dstore = $urandom;
            bus.dWEN   = 1'b0;
            bus.dREN   = 1'b1;
         end
         t = 0;
         do begin
            @(negedge CLK);
            t++;
         end while (bus.dwait !== 1'b0 && t < 200);
         if (t >= 200) chk("d_timeout", 32'd1, 32'd0);
         cyc();
         bus.dREN = 1'b0;
         bus.dWEN = 1'b0;
      end
   endtask

   initial begin
      int t;
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b1; bus.dWEN = 1'b0;
      bus.daddr = 32'h800; bus.dstore = '0;
      nRST = 1'b0;

      // Reset holds everything quiet even with both requests raised.
      repeat (2) begin
         @(negedge CLK);
         chk("rst_iwait", {31'b0, bus.iwait}, 32'd1);
         chk("rst_dwait", {31'b0, bus.dwait}, 32'd1);
         chk("rst_ramREN", {31'b0, bus.ramREN}, 32'd0);
         chk("rst_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
         chk("rst_ramaddr", bus.ramaddr, 32'd0);
         chk("rst_ramstore", bus.ramstore, 32'd0);
         chk("rst_loads", bus.iload | bus.dload, 32'd0);
         chk("rst_merr", {31'b0, bus.merr}, 32'd0);
      end
      cyc();
      bus.iREN = 1'b0; bus.dREN = 1'b0; nRST = 1'b1;
      repeat (2) cyc();

      // Instruction fetch with two BUSY cycles.
      dir_lat = 2;
      iq.push_back('{32'h40, 32'h8C010004, 1'b0});
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      @(negedge CLK);
      chk("t2_idle_ramREN", {31'b0, bus.ramREN}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk("t2_ramaddr", bus.ramaddr, 32'h40);
         chk("t2_ramREN", {31'b0, bus.ramREN}, 32'd1);
         chk("t2_iwait", {31'b0, bus.iwait}, (c == 2) ? 32'd0 : 32'd1);
      end
      cyc();
      bus.iREN = 1'b0;
      @(negedge CLK);
      chk("t2_turnaround", {31'b0, bus.ramREN}, 32'd0);

      // Unaligned data write.
      cyc();
      dir_lat = 1;
      ref_mem[32'h400] = 32'hDEADBEEF;
      dq.push_back('{32'h1000, 32'hDEADBEEF, 1'b1});
      bus.dWEN = 1'b1; bus.daddr = 32'h1003; bus.dstore = 32'hDEADBEEF;
      @(negedge CLK);
      @(negedge CLK);
      chk("t3_ramaddr", bus.ramaddr, 32'h1000);
      chk("t3_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
      chk("t3_ramREN", {31'b0, bus.ramREN}, 32'd0);
      chk("t3_ramstore", bus.ramstore, 32'hDEADBEEF);
      chk("t3_dwait_busy", {31'b0, bus.dwait}, 32'd1);
      @(negedge CLK);
      chk("t3_dwait_done", {31'b0, bus.dwait}, 32'd0);
      cyc();
      bus.dWEN = 1'b0;
      cyc();

      // Sustained traffic on both sides: every (LIM+1)-th grant must go to the instruction side.
      dir_lat = 0;
      for (int k = 0; k < 10; k++) begin
         gq.push_back(((k + 1) % (LIM + 1)) == 0);
         if (((k + 1) % (LIM + 1)) == 0) iq.push_back('{32'h40, ref_mem[16], 1'b0});
         else                            dq.push_back('{32'h800, ref_mem[32'h200], 1'b0});
      end
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b1; bus.daddr = 32'h800;
      t = 0;
      while (gq.size() > 0 && t < 200) begin
         @(negedge CLK);
         #1;
         t++;
      end
      chk("seq_left", 32'(gq.size()), 32'd0);
      cyc();
      bus.iREN = 1'b0; bus.dREN = 1'b0;
      cyc();

      // RAM error on a data read, then the natural retry.
      dir_lat = 0; dir_err = 1;
      dq.push_back('{32'h800, ref_mem[32'h200], 1'b0});
      bus.dREN = 1'b1; bus.daddr = 32'h800;
      @(negedge CLK);
      @(negedge CLK);
      chk("t5_merr", {31'b0, bus.merr}, 32'd1);
      chk("t5_dwait", {31'b0, bus.dwait}, 32'd1);
      @(negedge CLK);
      chk("t5_merr_pulse", {31'b0, bus.merr}, 32'd0);
      chk("t5_idle", {31'b0, bus.ramREN}, 32'd0);
      @(negedge CLK);
      chk("t5_retry_done", {31'b0, bus.dwait}, 32'd0);
      cyc();
      bus.dREN = 1'b0;
      cyc();

      // Instruction abort after one BUSY cycle while a data read waits.
      dir_lat = 3;
      bus.iREN = 1'b1; bus.iaddr = 32'h80;
      @(negedge CLK);
      cyc();
      dq.push_back('{32'h804, ref_mem[32'h201], 1'b0});
      bus.dREN = 1'b1; bus.daddr = 32'h804;
      @(negedge CLK);
      chk("t6_igrant", {31'b0, bus.ramREN}, 32'd1);
      chk("t6_iaddr", bus.ramaddr, 32'h80);
      cyc();
      bus.iREN = 1'b0;
      @(negedge CLK);
      chk("t6_abort_ramREN", {31'b0, bus.ramREN}, 32'd0);
      chk("t6_abort_iwait", {31'b0, bus.iwait}, 32'd1);
      @(negedge CLK);
      chk("t6_idle", {31'b0, bus.ramREN}, 32'd0);
      @(negedge CLK);
      chk("t6_dgrant", {31'b0, bus.ramREN}, 32'd1);
      chk("t6_daddr", bus.ramaddr, 32'h804);
      t = 0;
      while (dq.size() > 0 && t < 50) begin
         @(negedge CLK);
         #1;
         t++;
      end
      chk("t6_d_done", 32'(dq.size()), 32'd0);
      cyc();
      bus.dREN = 1'b0;
      cyc();

      // Reset asserted in the middle of a granted fetch.
      dir_lat = 5;
      bus.iREN = 1'b1; bus.iaddr = 32'h84;
      @(negedge CLK);
      @(negedge CLK);
      @(posedge CLK);
      #3;
      nRST = 1'b0;
      #1;
      chk("mr_ramREN", {31'b0, bus.ramREN}, 32'd0);
      chk("mr_iwait", {31'b0, bus.iwait}, 32'd1);
      chk("mr_ramaddr", bus.ramaddr, 32'd0);
      bus.iREN = 1'b0;
      repeat (2) cyc();
      nRST = 1'b1;
      repeat (2) cyc();

      // Randomised concurrent traffic from both caches.
      rand_mode = 1;
      fork
         icache_run(40);
         dcache_run(40);
      join
      repeat (3) cyc();
      chk("drain_iq", 32'(iq.size()), 32'd0);
      chk("drain_dq", 32'(dq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
